rd_b_weight_stream: RTL and testbench
=====================================

# rd_b_weight_stream

Parametrised successor to the FC-layer weight reader. It streams a run-time-selectable number of weight rows from the weight BRAM, each `ICH_T*W_BW` bits wide, at a programmable address stride. Downstream back-pressure is absorbed by a credit-controlled output FIFO, and the BRAM read latency is configurable. It sits between the layer controller and the MAC array, feeding one weight row per accepted beat.

## Interface
- `OCH`, 120, total output channels
- `ICH`, 400, total input channels
- `OCH_B`, 8, output-channel blocks; `OCH_T = OCH/OCH_B` (15)
- `ICH_B`, 40, input-channel blocks; `ICH_T = ICH/ICH_B` (10)
- `W_BW`, 8, weight bit width; `DATA_W = ICH_T*W_BW` (80)
- `RD_LAT`, 1, BRAM read latency in cycles, legal 1..3; FIFO depth `FD = RD_LAT+2`
- Derived: `DEPTH = OCH*ICH_B` (4800), `ADDR_W = $clog2(DEPTH)` (13), `LEN_W = $clog2(OCH_T+1)` (4), `IDX_W = $clog2(OCH_T)` (4)

Ports:
- `clk`, in, 1, clock
- `areset`, in, 1, reset; synchronous, active-high
- `i_run`, in, 1, one-cycle start pulse
- `i_rd_start_addr`, in, `ADDR_W`, first row address
- `i_rd_len`, in, `LEN_W`, rows to read, legal 1..`OCH_T`
- `i_rd_stride`, in, `ADDR_W`, address increment per row, legal 0..`DEPTH-1` (nominally `ICH_B`)
- `i_ot_ready`, in, 1, downstream accepts beat
- `o_idle`, out, 1, block idle
- `o_run`, out, 1, burst in progress
- `o_en_err`, out, 1, sticky error flag
- `o_ot_valid`, out, 1, output beat valid
- `o_ot_last`, out, 1, current beat is the last of the burst
- `o_ot_done`, out, 1, one-cycle pulse after the last beat is accepted
- `o_ot_idx`, out, `IDX_W`, beat index within the burst
- `o_ot_weight`, out, `DATA_W`, weight row (FIFO head)
- `b_o_weight_addr`, out, `ADDR_W`, BRAM address (registered)
- `b_o_weight_ce`, out, 1, BRAM enable
- `b_o_weight_we`, out, 1, constant 0
- `b_i_weight_q`, in, `DATA_W`, BRAM read data

## Operation
State machine:
- **IDLE**: `o_idle=1`.
  - On `i_run` with a legal `i_rd_len`: latch len and stride, load addr with `i_rd_start_addr`, clear issue/beat counters, go to **ISSUE**.
  - On `i_run` with `i_rd_len==0` or `i_rd_len>OCH_T`: set `o_en_err`, stay in IDLE.

**ISSUE**:
- Issue condition: a read issues in a cycle when `fifo_cnt + inflight < FD` and `issued < len`.
- On an issue cycle: `b_o_weight_ce=1`. On the next edge, advance addr by stride.
- When `issued == len`, go to **DRAIN**.

**DRAIN**: wait until all beats are accepted, then pulse `o_ot_done` and return to IDLE.

Address arithmetic:
- Compute `sum = addr + stride` in `ADDR_W+1` bits.
- Next addr is `sum - DEPTH` if `sum >= DEPTH`, else `sum`, i.e. modulo-`DEPTH` wrap.
- `stride=0` re-reads the same row `len` times.

Read pipeline and FIFO:
- A `RD_LAT`-deep valid shift register tracks in-flight reads.
- When its tail is 1, `b_i_weight_q` is pushed into the FIFO.
- The credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design bug and must be caught by an assertion.

Output beats:
- `o_ot_valid = !fifo_empty`, and `o_ot_weight` is the FIFO head.
- The head stays stable while `valid && !ready`.
- A beat transfers on `valid && ready`.
- `o_ot_idx` increments on each transfer.
- `o_ot_last = o_ot_valid && (o_ot_idx == len-1)`.

Error and reset handling:
- `i_run` while not IDLE is ignored and sets `o_en_err`; the burst in progress is unaffected.
- `o_en_err` clears only on `areset`.
- `areset` mid-burst discards all in-flight and FIFO data and returns the block to IDLE.

## Timing
- Reset values:
  - `o_idle=1`
  - `o_run`, `o_en_err`, `o_ot_valid`, `o_ot_last`, `o_ot_done`, `b_o_weight_ce` = 0
  - `o_ot_idx=0`, `b_o_weight_addr=0`, `b_o_weight_we=0`
- Start latency: with `i_run` in cycle 0, the first address is on `b_o_weight_addr` in cycle 1, and the first `o_ot_valid` is in cycle `2+RD_LAT`.
- Throughput with `i_ot_ready` held high: one beat per cycle, no bubbles. The last beat is in cycle `1+RD_LAT+len`, and `o_ot_done` pulses the following cycle.
- `o_run` is high from cycle 1 through the `o_ot_done` cycle inclusive. `o_idle = !o_run`.
- A new `i_run` is accepted in the cycle after `o_ot_done` (back-to-back bursts). `i_run` in the same cycle as `o_ot_done` is an error.
- Back-pressure:
  - Issuing stalls at most `FD` beats ahead of acceptance.
  - Deasserting `i_ot_ready` for N cycles delays `o_ot_done` by exactly N cycles when the FIFO is full.

## Test plan
- **Nominal burst**: start 0, len 15, stride 40, `RD_LAT=1`, ready=1 → addrs 0,40,…,560. Valid cycles 3..17, idx 0..14, last at idx 14, done in cycle 18.
- **Back-pressure**: ready toggles 1,0,0,1 repeatedly → no beat lost or duplicated, data stable while stalled, FIFO never exceeds `FD`, done after the 15th accept.
- **Wrap-around**: start 4790, len 3, stride 40 → addrs 4790, 30, 70.
- **Short and re-read**: len 1 → single beat with last=1 and idx=0. Stride 0, len 4 → same address 4 times.
- **Errors**: `i_rd_len=0` → `o_en_err=1` and stays idle. `i_run` mid-burst → `o_en_err=1` and the burst completes unchanged.
- **Reset mid-burst plus latency sweep**: `areset` at beat 5 → all outputs at reset values next cycle, a following burst is correct. Repeat the nominal case with `RD_LAT=2` and `RD_LAT=3`: first valid in cycles 4 and 5 respectively.

Source files
------------

// File: rtl/rd_b_weight_stream.sv
// Weight-row streamer: issues a strided burst of BRAM reads and hands the rows
// to the MAC array through a small credit-limited FIFO that absorbs back-pressure.
module rd_b_weight_stream #(
   parameter int OCH    = 120,
   parameter int ICH    = 400,
   parameter int OCH_B  = 8,
   parameter int ICH_B  = 40,
   parameter int W_BW   = 8,
   parameter int RD_LAT = 1,
   localparam int OCH_T  = OCH / OCH_B,
   localparam int ICH_T  = ICH / ICH_B,
   localparam int DATA_W = ICH_T * W_BW,
   localparam int DEPTH  = OCH * ICH_B,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int LEN_W  = $clog2(OCH_T + 1),
   localparam int IDX_W  = $clog2(OCH_T)
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              i_run,
   input  logic [ADDR_W-1:0] i_rd_start_addr,
   input  logic [LEN_W-1:0]  i_rd_len,
   input  logic [ADDR_W-1:0] i_rd_stride,
   input  logic              i_ot_ready,
   output logic              o_idle,
   output logic              o_run,
   output logic              o_en_err,
   output logic              o_ot_valid,
   output logic              o_ot_last,
   output logic              o_ot_done,
   output logic [IDX_W-1:0]  o_ot_idx,
   output logic [DATA_W-1:0] o_ot_weight,
   output logic [ADDR_W-1:0] b_o_weight_addr,
   output logic              b_o_weight_ce,
   output logic              b_o_weight_we,
   input  logic [DATA_W-1:0] b_i_weight_q
);

   localparam int FD    = RD_LAT + 2;
   localparam int CNT_W = $clog2(FD + 1);
   localparam int PTR_W = $clog2(FD);
   localparam int INF_W = $clog2(RD_LAT + 1);
   localparam int CRD_W = $clog2(FD + RD_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t state, state_nx;

   logic [LEN_W-1:0]  len_r;
   logic [ADDR_W-1:0] stride_r;
   logic [ADDR_W-1:0] addr_p0;
   logic [LEN_W-1:0]  issued;
   logic [IDX_W-1:0]  beat_idx;
   logic              err_r;
   logic [RD_LAT-1:0] vld_p;
   logic [INF_W-1:0]  inflight;
   logic [DATA_W-1:0] fifo_mem [FD];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              len_ok, start, credit_ok, issue, push, pop;
   logic [LEN_W-1:0]  len_m1;

   // Modulo-DEPTH address step; both operands are below DEPTH so one subtract suffices.
   function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] s);
      logic [ADDR_W:0] sum;
      sum = {1'b0, a} + {1'b0, s};
      if (sum >= (ADDR_W+1)'(DEPTH))
         sum = sum - (ADDR_W+1)'(DEPTH);
      return sum[ADDR_W-1:0];
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FD - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++)
         inflight = inflight + INF_W'(vld_p[i]);
   end

   assign len_ok    = (i_rd_len != '0) && (i_rd_len <= LEN_W'(OCH_T));
   assign start     = (state == S_IDLE) && i_run && len_ok;
   // Reads still in the BRAM pipe already own a FIFO slot.
   assign credit_ok = (CRD_W'(fifo_cnt) + CRD_W'(inflight)) < CRD_W'(FD);
   assign issue     = (state == S_ISSUE) && (issued < len_r) && credit_ok;
   assign push      = vld_p[RD_LAT-1];
   assign pop       = o_ot_valid && i_ot_ready;
   assign len_m1    = len_r - LEN_W'(1);

   always_ff @(posedge clk) begin
      if (areset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_ISSUE;
         S_ISSUE: if (issued == len_r) state_nx = S_DRAIN;
         S_DRAIN: if (pop && o_ot_last) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Issue stage: address, counters, read-valid pipe, FIFO bookkeeping
   always_ff @(posedge clk) begin
      if (areset) begin
         addr_p0  <= '0;
         issued   <= '0;
         beat_idx <= '0;
         err_r    <= 1'b0;
         vld_p    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (i_run && ((state != S_IDLE) || !len_ok))
            err_r <= 1'b1;
         if (start) begin
            addr_p0  <= i_rd_start_addr;
            issued   <= '0;
            beat_idx <= '0;
         end else begin
            if (issue) begin
               addr_p0 <= wrap_add(addr_p0, stride_r);
               issued  <= issued + LEN_W'(1);
            end
            if (pop)
               beat_idx <= beat_idx + IDX_W'(1);
         end
         vld_p <= (vld_p << 1) | RD_LAT'(issue);
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Data stage: burst configuration and FIFO storage
   always_ff @(posedge clk) begin
      if (start) begin
         len_r    <= i_rd_len;
         stride_r <= i_rd_stride;
      end
      if (push)
         fifo_mem[wr_ptr] <= b_i_weight_q;
   end

   assert property (@(posedge clk) disable iff (areset) !(push && (fifo_cnt == CNT_W'(FD))));

   assign o_idle          = (state == S_IDLE);
   assign o_run           = !o_idle;
   assign o_en_err        = err_r;
   assign o_ot_valid      = (fifo_cnt != '0);
   assign o_ot_last       = o_ot_valid && (LEN_W'(beat_idx) == len_m1);
   assign o_ot_done       = (state == S_DONE);
   assign o_ot_idx        = beat_idx;
   assign o_ot_weight     = fifo_mem[rd_ptr];
   assign b_o_weight_addr = addr_p0;
   assign b_o_weight_ce   = issue;
   assign b_o_weight_we   = 1'b0;

endmodule

// File: tb/tb_rd_b_weight_stream.sv
// Bench for rd_b_weight_stream: three instances (read latency 1..3) share stimulus,
// each backed by its own BRAM model; instance 0 is checked beat by beat via a scoreboard.
module tb_rd_b_weight_stream;
   localparam int DEPTH = 4800;
   localparam int AW    = 13;
   localparam int LW    = 4;
   localparam int IW    = 4;
   localparam int DW    = 80;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [IW-1:0] i;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          areset;
   logic          i_run;
   logic [AW-1:0] start_addr;
   logic [LW-1:0] rd_len;
   logic [AW-1:0] stride;
   logic          ready;

   logic          idle [3];
   logic          run  [3];
   logic          err  [3];
   logic          valid[3];
   logic          last [3];
   logic          done [3];
   logic          ce   [3];
   logic          we   [3];
   logic [IW-1:0] idx  [3];
   logic [DW-1:0] weight[3];
   logic [DW-1:0] q    [3];
   logic [AW-1:0] addr [3];

   int errors = 0;
   int checks = 0;
   beat_t         exp_q[$];
   logic [AW-1:0] addr_q[$];

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] wdata(input logic [AW-1:0] a);
      return {{6{a ^ 13'h0A5A}}, 2'b11};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [DW-1:0] pipe [3];

      rd_b_weight_stream #(.RD_LAT(g + 1)) u_dut (
         .clk             (clk),
         .areset          (areset),
         .i_run           (i_run),
         .i_rd_start_addr (start_addr),
         .i_rd_len        (rd_len),
         .i_rd_stride     (stride),
         .i_ot_ready      (ready),
         .o_idle          (idle[g]),
         .o_run           (run[g]),
         .o_en_err        (err[g]),
         .o_ot_valid      (valid[g]),
         .o_ot_last       (last[g]),
         .o_ot_done       (done[g]),
         .o_ot_idx        (idx[g]),
         .o_ot_weight     (weight[g]),
         .b_o_weight_addr (addr[g]),
         .b_o_weight_ce   (ce[g]),
         .b_o_weight_we   (we[g]),
         .b_i_weight_q    (q[g])
      );

      always @(posedge clk) begin
         pipe[0] <= ce[g] ? wdata(addr[g]) : {10{8'hEE}};
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign q[g] = pipe[g];
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_idle",  idle[0],  1);
      chk("rst_run",   run[0],   0);
      chk("rst_err",   err[0],   0);
      chk("rst_valid", valid[0], 0);
      chk("rst_last",  last[0],  0);
      chk("rst_done",  done[0],  0);
      chk("rst_ce",    ce[0],    0);
      chk("rst_idx",   idx[0],   0);
      chk("rst_addr",  addr[0],  0);
      chk("rst_we",    we[0],    0);
   endtask

   // One burst; bp selects the 1,0,0,1 ready pattern, inj injects a stray i_run,
   // rst_at asserts areset during that cycle and checks reset values the next.
   task automatic burst(input int start, input int len, input int str,
                        input bit bp, input int inj, input int rst_at);
      int ea;
      int c;
      int first[3];
      int donec[3];
      bit pv, pr, rst_hit;
      logic [DW-1:0] pw;
      beat_t b;
      exp_q.delete();
      addr_q.delete();
      ea = start;
      for (int k = 0; k < len; k++) begin
         addr_q.push_back(AW'(ea));
         exp_q.push_back('{a: AW'(ea), i: IW'(k), l: (k == len - 1)});
         ea = (ea + str) % DEPTH;
      end
      @(posedge clk); #1;
      i_run = 1'b1; start_addr = AW'(start); rd_len = LW'(len); stride = AW'(str); ready = 1'b1;
      @(posedge clk);
      first = '{-1, -1, -1};
      donec = '{-1, -1, -1};
      pv = 1'b0; pr = 1'b1; pw = '0; rst_hit = 1'b0;
      c = 1;
      while (c < 300) begin
         #1;
         i_run = (c == inj);
         if (c == inj) begin
            start_addr = 13'd77; rd_len = 4'd2; stride = 13'd5;
         end
         ready  = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         areset = (c == rst_at);
         @(negedge clk);
         if (c == rst_at + 1) begin
            check_reset();
            rst_hit = 1'b1;
            break;
         end
         if (ce[0]) begin
            checks++;
            assert (addr_q.size() > 0) else begin
               errors++;
               $error("FAIL extra_issue observed=%0d expected=none", addr[0]);
            end
            if (addr_q.size() > 0) chk("issue_addr", addr[0], addr_q.pop_front());
         end
         if (pv && !pr) begin
            chk("stall_valid", valid[0], 1);
            chk("stall_hold", weight[0], pw);
         end
         if (valid[0] && ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL extra_beat observed=%0h expected=none", weight[0]);
            end
            if (exp_q.size() > 0) begin
               b = exp_q.pop_front();
               chk("beat_weight", weight[0], wdata(b.a));
               chk("beat_idx", idx[0], b.i);
               chk("beat_last", last[0], b.l);
            end
         end
         if (donec[0] >= 0 && c == donec[0] + 1) chk("idle_after_done", idle[0], 1);
         pv = valid[0]; pr = ready; pw = weight[0];
         for (int g = 0; g < 3; g++) begin
            if (valid[g] && first[g] < 0) first[g] = c;
            if (done[g] && donec[g] < 0) begin
               donec[g] = c;
               if (g == 0) begin
                  chk("done_beats_left", exp_q.size(), 0);
                  chk("done_issues_left", addr_q.size(), 0);
                  chk("run_in_done", run[0], 1);
               end
            end
         end
         if (donec[0] >= 0 && donec[1] >= 0 && donec[2] >= 0) break;
         @(posedge clk);
         c++;
      end
      i_run = 1'b0;
      if (!rst_hit) begin
         for (int g = 0; g < 3; g++) begin
            checks++;
            assert (donec[g] >= 0) else begin
               errors++;
               $error("FAIL timeout_lat%0d observed=no_done expected=done", g + 1);
            end
            chk($sformatf("first_valid_lat%0d", g + 1), first[g], 3 + g);
            if (!bp) chk($sformatf("done_cycle_lat%0d", g + 1), donec[g], 3 + g + len);
         end
      end
   endtask

   initial begin
      areset = 1'b1; i_run = 1'b0; start_addr = '0; rd_len = '0; stride = '0; ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset();
      @(posedge clk); #1 areset = 1'b0;

      burst(0, 15, 40, 1'b0, -1, -1);
      burst(0, 15, 40, 1'b1, -1, -1);
      burst(4790, 3, 40, 1'b0, -1, -1);
      burst(123, 1, 40, 1'b0, -1, -1);
      burst(9, 4, 0, 1'b0, -1, -1);

      @(posedge clk); #1;
      i_run = 1'b1; rd_len = '0;
      @(posedge clk); #1 i_run = 1'b0;
      @(negedge clk);
      chk("len0_err", err[0], 1);
      chk("len0_idle", idle[0], 1);
      chk("len0_ce", ce[0], 0);
      repeat (3) @(negedge clk);
      chk("len0_no_beat", valid[0], 0);

      @(posedge clk); #1 areset = 1'b1;
      @(posedge clk); #1 areset = 1'b0;
      @(negedge clk);
      check_reset();

      burst(200, 6, 40, 1'b0, 4, -1);
      chk("midburst_run_err", err[0], 1);

      burst(0, 15, 40, 1'b0, -1, 8);
      burst(500, 5, 40, 1'b0, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
